// File: rtl/vend_output_ctrl.sv
// vend_output_ctrl: credit state register, timed dispense/cooldown FSM, coin reject and vend counter; define VEND_REFUND_EN for cancel-driven refunds
module vend_output_ctrl #(
  parameter int DISP_CYCLES = 4,
  parameter int COOL_CYCLES = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       snext,
  input  logic             coin_valid,
  input  logic             cancel,
  output logic [2:0]       state,
  output logic             dispense,
  output logic             busy,
  output logic             coin_reject,
  output logic             refund_pulse,
  output logic [CNT_W-1:0] vend_count
);
  typedef enum logic [1:0] {IDLE, DISPENSE, COOLDOWN, REFUND} fsm_t;
  localparam int CW = $clog2(DISP_CYCLES + COOL_CYCLES + 1);
  localparam logic [CW-1:0] DLOAD = CW'(DISP_CYCLES - 1);
  localparam logic [CW-1:0] CLOAD = CW'(COOL_CYCLES > 0 ? COOL_CYCLES - 1 : 0);
  fsm_t fsm, fsm_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] state_n;
  logic ph, ph_n;
  logic inc;
  assign busy = fsm != IDLE;
  assign dispense = fsm == DISPENSE;
`ifdef VEND_REFUND_EN
  assign refund_pulse = (fsm == REFUND) && !ph;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign refund_pulse = 1'b0;
`endif
  // next-state: coin acceptance in IDLE, dispense/cooldown timing, refund stepping
  always_comb begin
    fsm_n = fsm;
    cnt_n = cnt;
    state_n = state;
    ph_n = ph;
    inc = 1'b0;
    case (fsm)
      IDLE: begin
        if (coin_valid) begin
          state_n = snext[2:0];
          fsm_n = snext[3] ? DISPENSE : IDLE;
          cnt_n = DLOAD;
        end
`ifdef VEND_REFUND_EN
        else if (cancel && state != 3'd0) begin
          fsm_n = REFUND;
          ph_n = 1'b0;
        end
`endif
      end
      DISPENSE: begin
        cnt_n = cnt - 1'b1;
        if (cnt == '0) begin
          inc = 1'b1;
          fsm_n = COOL_CYCLES == 0 ? IDLE : COOLDOWN;
          cnt_n = CLOAD;
        end
      end
      COOLDOWN: begin
        cnt_n = cnt - 1'b1;
        fsm_n = cnt == '0 ? IDLE : COOLDOWN;
      end
      REFUND: begin
`ifdef VEND_REFUND_EN
        if (!ph) begin
          state_n = state - 3'd1;
          ph_n = 1'b1;
        end else begin
          fsm_n = state == 3'd0 ? IDLE : REFUND;
          ph_n = 1'b0;
        end
`else
        fsm_n = IDLE;
`endif
      end
      default: fsm_n = IDLE;
    endcase
  end
  // state register, reject strobe and saturating vend counter; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm <= IDLE;
      cnt <= '0;
      state <= '0;
      ph <= 1'b0;
      coin_reject <= 1'b0;
      vend_count <= '0;
    end else begin
      fsm <= fsm_n;
      cnt <= cnt_n;
      state <= state_n;
      ph <= ph_n;
      coin_reject <= coin_valid & busy;
      if (inc && !(&vend_count)) vend_count <= vend_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_vend_output_ctrl.sv
// tb_vend_output_ctrl: scoreboard bench for vend_output_ctrl, expected outputs queued per driven cycle
module tb_vend_output_ctrl;
  logic clk = 1'b0, reset = 1'b1, coin_valid = 1'b0, cancel = 1'b0;
  logic [3:0] snext = 4'd0;
  logic [2:0] state;
  logic dispense, busy, coin_reject, refund_pulse;
  logic [7:0] vend_count;
  typedef struct packed {logic [2:0] st; logic d; logic b; logic r; logic p; logic [7:0] vc;} exp_t;
  exp_t sb[$];
  logic [7:0] sat_q[$];
  int errors = 0, checks = 0;

  vend_output_ctrl dut (
    .clk(clk), .reset(reset), .snext(snext), .coin_valid(coin_valid), .cancel(cancel),
    .state(state), .dispense(dispense), .busy(busy), .coin_reject(coin_reject),
    .refund_pulse(refund_pulse), .vend_count(vend_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t exp_v(input int st, d, b, r, p, vc);
    return {3'(st), 1'(d), 1'(b), 1'(r), 1'(p), 8'(vc)};
  endfunction
  function automatic logic [6:0] stim_v(input int rs, cv, cn, sn);
    return {1'(rs), 1'(cv), 1'(cn), 4'(sn)};
  endfunction
  function automatic exp_t obs();
    return {state, dispense, busy, coin_reject, refund_pulse, vend_count};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] s[2];
    exp_t x[2];
    exp_t e;
    s = '{stim_v(1, 1, 0, 15), stim_v(1, 1, 0, 15)};
    x = '{exp_v(0, 0, 0, 0, 0, 0), exp_v(0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 2; i++) begin
      {reset, coin_valid, cancel, snext} = s[i];
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset[%0d]: got %p want %p", i, obs(), e); end
    end
  endtask

  task automatic test_accept();
    logic [6:0] s[2];
    exp_t x[2];
    exp_t e;
    s = '{stim_v(0, 1, 0, 3), stim_v(0, 0, 0, 15)};
    x = '{exp_v(3, 0, 0, 0, 0, 0), exp_v(3, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 2; i++) begin
      {reset, coin_valid, cancel, snext} = s[i];
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL accept[%0d]: got %p want %p", i, obs(), e); end
    end
  endtask

  task automatic test_vend();
    logic [6:0] s[7];
    exp_t x[7];
    exp_t e;
    s = '{stim_v(0, 1, 0, 9), stim_v(0, 0, 0, 0), stim_v(0, 0, 0, 0), stim_v(0, 0, 0, 0),
          stim_v(0, 0, 0, 0), stim_v(0, 0, 0, 0), stim_v(0, 0, 0, 0)};
    x = '{exp_v(1, 1, 1, 0, 0, 0), exp_v(1, 1, 1, 0, 0, 0), exp_v(1, 1, 1, 0, 0, 0),
          exp_v(1, 1, 1, 0, 0, 0), exp_v(1, 0, 1, 0, 0, 1), exp_v(1, 0, 1, 0, 0, 1),
          exp_v(1, 0, 0, 0, 0, 1)};
    for (int i = 0; i < 7; i++) begin
      {reset, coin_valid, cancel, snext} = s[i];
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL vend[%0d]: got %p want %p", i, obs(), e); end
    end
  endtask

  task automatic test_reject();
    logic [6:0] s[7];
    exp_t x[7];
    exp_t e;
    s = '{stim_v(0, 1, 0, 10), stim_v(0, 0, 0, 0), stim_v(0, 1, 0, 7), stim_v(0, 0, 0, 0),
          stim_v(0, 0, 0, 0), stim_v(0, 0, 0, 0), stim_v(0, 0, 0, 0)};
    x = '{exp_v(2, 1, 1, 0, 0, 1), exp_v(2, 1, 1, 0, 0, 1), exp_v(2, 1, 1, 1, 0, 1),
          exp_v(2, 1, 1, 0, 0, 1), exp_v(2, 0, 1, 0, 0, 2), exp_v(2, 0, 1, 0, 0, 2),
          exp_v(2, 0, 0, 0, 0, 2)};
    for (int i = 0; i < 7; i++) begin
      {reset, coin_valid, cancel, snext} = s[i];
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL reject[%0d]: got %p want %p", i, obs(), e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] s[9];
    exp_t x[9];
    exp_t e;
    s = '{stim_v(0, 1, 0, 11), stim_v(0, 0, 0, 0), stim_v(0, 0, 0, 0), stim_v(0, 0, 0, 0),
          stim_v(0, 0, 0, 0), stim_v(0, 1, 0, 5), stim_v(0, 1, 0, 5), stim_v(0, 1, 0, 5),
          stim_v(0, 0, 0, 0)};
    x = '{exp_v(3, 1, 1, 0, 0, 2), exp_v(3, 1, 1, 0, 0, 2), exp_v(3, 1, 1, 0, 0, 2),
          exp_v(3, 1, 1, 0, 0, 2), exp_v(3, 0, 1, 0, 0, 3), exp_v(3, 0, 1, 1, 0, 3),
          exp_v(3, 0, 0, 1, 0, 3), exp_v(5, 0, 0, 0, 0, 3), exp_v(5, 0, 0, 0, 0, 3)};
    for (int i = 0; i < 9; i++) begin
      {reset, coin_valid, cancel, snext} = s[i];
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL back_to_back[%0d]: got %p want %p", i, obs(), e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] s[5];
    exp_t x[5];
    exp_t e;
    s = '{stim_v(0, 1, 0, 9), stim_v(0, 0, 0, 0), stim_v(0, 0, 0, 0), stim_v(1, 0, 0, 0),
          stim_v(0, 0, 0, 0)};
    x = '{exp_v(1, 1, 1, 0, 0, 3), exp_v(1, 1, 1, 0, 0, 3), exp_v(1, 1, 1, 0, 0, 3),
          exp_v(0, 0, 0, 0, 0, 0), exp_v(0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      {reset, coin_valid, cancel, snext} = s[i];
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset_mid[%0d]: got %p want %p", i, obs(), e); end
    end
  endtask

`ifdef VEND_REFUND_EN
  task automatic test_refund();
    logic [6:0] s[8];
    exp_t x[8];
    exp_t e;
    s = '{stim_v(0, 1, 0, 3), stim_v(0, 0, 1, 0), stim_v(0, 0, 0, 0), stim_v(0, 1, 0, 7),
          stim_v(0, 0, 0, 0), stim_v(0, 0, 0, 0), stim_v(0, 0, 0, 0), stim_v(0, 0, 0, 0)};
    x = '{exp_v(3, 0, 0, 0, 0, 0), exp_v(3, 0, 1, 0, 1, 0), exp_v(2, 0, 1, 0, 0, 0),
          exp_v(2, 0, 1, 1, 1, 0), exp_v(1, 0, 1, 0, 0, 0), exp_v(1, 0, 1, 0, 1, 0),
          exp_v(0, 0, 1, 0, 0, 0), exp_v(0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 8; i++) begin
      {reset, coin_valid, cancel, snext} = s[i];
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL refund[%0d]: got %p want %p", i, obs(), e); end
    end
  endtask
`else
  task automatic test_refund();
    logic [6:0] s[3];
    exp_t x[3];
    exp_t e;
    s = '{stim_v(0, 1, 0, 3), stim_v(0, 0, 1, 0), stim_v(0, 0, 0, 0)};
    x = '{exp_v(3, 0, 0, 0, 0, 0), exp_v(3, 0, 0, 0, 0, 0), exp_v(3, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 3; i++) begin
      {reset, coin_valid, cancel, snext} = s[i];
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL cancel_ignored[%0d]: got %p want %p", i, obs(), e); end
    end
  endtask
`endif

  task automatic test_saturate();
    logic [7:0] want;
    for (int n = 1; n <= 260; n++) begin
      coin_valid = 1'b1;
      snext = 4'b1000;
      sat_q.push_back(8'(n > 255 ? 255 : n));
      tick();
      coin_valid = 1'b0;
      snext = 4'd0;
      repeat (6) tick();
      want = sat_q.pop_front();
      checks++;
      if (vend_count !== want || busy !== 1'b0) begin
        errors++;
        $display("FAIL saturate[%0d]: got count=%0d busy=%b want count=%0d busy=0", n, vend_count, busy, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_vend();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    test_refund();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
